// File: rtl/kim_counter_arbiter.sv
// Round-robin scheduler sharing one counter-control/counter pair between NUM_REQ requesters.
// Grants one owner at a time, pulses start, waits for done (or watchdog), then returns a done pulse.
module kim_counter_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int CNT_DATA_WIDTH = 7,
   parameter int WDOG_CYCLES    = 256
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_i,
   input  logic [NUM_REQ*CNT_DATA_WIDTH-1:0] req_cnt_val_i,
   output logic [NUM_REQ-1:0]                grant_o,
   output logic [NUM_REQ-1:0]                done_o,
   output logic                              busy_o,
   output logic                              err_o,
   input  logic                              err_clr_i,
   output logic                              start_o,
   output logic [CNT_DATA_WIDTH-1:0]         cnt_val_o,
   input  logic                              cnt_done_i
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RELEASE
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [IDX_W-1:0]          owner;
   logic [IDX_W-1:0]          ptr;
   logic [IDX_W-1:0]          pick;
   logic                      pick_vld;
   logic [CNT_DATA_WIDTH-1:0] cnt_val;
   logic [WDOG_W-1:0]         wdog;
   logic                      err;
   logic [NUM_REQ-1:0]        owner_oh;
   logic [CNT_DATA_WIDTH-1:0] lens [NUM_REQ];
   logic                      load;
   logic                      wdog_clr;
   logic                      wdog_inc;
   logic                      wdog_expire;
   logic                      ptr_adv;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_lens
      assign lens[k] = req_cnt_val_i[k*CNT_DATA_WIDTH +: CNT_DATA_WIDTH];
   end

   // First set request at or above the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      int               j;
      logic [IDX_W-1:0] cand;
      pick_vld = 1'b0;
      pick     = '0;
      j        = 0;
      cand     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         cand = IDX_W'(j);
         if (!pick_vld && req_i[cand]) begin
            pick_vld = 1'b1;
            pick     = cand;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      wdog_clr    = 1'b0;
      wdog_inc    = 1'b0;
      wdog_expire = 1'b0;
      ptr_adv     = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               load      = 1'b1;
               // Zero length bypasses the counter, which would underflow on len-1.
               state_nxt = (lens[pick] != '0) ? START : RELEASE;
            end
         end
         START: begin
            wdog_clr  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt_done_i) begin
               state_nxt = RELEASE;
            end else if (wdog == WDOG_LAST) begin
               wdog_expire = 1'b1;
               state_nxt   = RELEASE;
            end else begin
               wdog_inc = 1'b1;
            end
         end
         RELEASE: begin
            ptr_adv   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner   <= '0;
         ptr     <= '0;
         cnt_val <= '0;
         wdog    <= '0;
         err     <= 1'b0;
      end else begin
         if (load) begin
            owner   <= pick;
            cnt_val <= lens[pick];
         end
         if (wdog_clr)      wdog <= '0;
         else if (wdog_inc) wdog <= wdog + 1'b1;
         if (ptr_adv) ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
         if (wdog_expire)    err <= 1'b1;
         else if (err_clr_i) err <= 1'b0;
      end
   end

   assign owner_oh  = NUM_REQ'(1) << owner;
   assign grant_o   = (state != IDLE)    ? owner_oh : '0;
   assign done_o    = (state == RELEASE) ? owner_oh : '0;
   assign start_o   = (state == START);
   assign busy_o    = (state != IDLE);
   assign err_o     = err;
   assign cnt_val_o = cnt_val;

endmodule

// File: tb/tb_kim_counter_arbiter.sv
// Randomized bench for kim_counter_arbiter: cycle-timed transaction model feeds an event
// scoreboard that a negedge monitor drains against the DUT's start/done pulses and status.
module tb_kim_counter_arbiter;

   localparam int N  = 4;
   localparam int W  = 7;
   localparam int WD = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_i;
   logic [N*W-1:0] req_cnt_val_i;
   logic [N-1:0]   grant_o;
   logic [N-1:0]   done_o;
   logic           busy_o;
   logic           err_o;
   logic           err_clr_i;
   logic           start_o;
   logic [W-1:0]   cnt_val_o;
   logic           cnt_done_i;

   kim_counter_arbiter #(
      .NUM_REQ(N), .CNT_DATA_WIDTH(W), .WDOG_CYCLES(WD)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .req_cnt_val_i(req_cnt_val_i),
      .grant_o(grant_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
      .err_clr_i(err_clr_i), .start_o(start_o), .cnt_val_o(cnt_val_o),
      .cnt_done_i(cnt_done_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit is_start;
      int owner;
      int len;
      bit err;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc      = 0;
   bit  mon_en   = 1'b0;
   int  resp_cd  = -1;

   // Model state: who owns the counter, when it was granted and when it is released.
   bit  m_busy  = 1'b0;
   bit  m_err   = 1'b0;
   int  m_owner = 0;
   int  m_len   = 0;
   int  m_ptr   = 0;
   int  m_arb   = 0;
   int  m_rel   = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_len();
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return W'($urandom_range(64, 127));
         default: return W'($urandom_range(1, 10));
      endcase
   endfunction

   // Reference model, evaluated on the inputs seen at each rising edge.
   always @(posedge clk) begin
      ev_t ev;
      bit  have_ev;
      bit  set_err;
      int  k;
      cyc++;
      have_ev = 1'b0;
      set_err = 1'b0;
      ev      = '{default: 0};
      if (rst) begin
         m_busy  = 1'b0;
         m_err   = 1'b0;
         m_owner = 0;
         m_len   = 0;
         m_ptr   = 0;
         m_rel   = -1;
         exp_q.delete();
      end else begin
         if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
               k = (m_ptr + i) % N;
               if (!m_busy && req_i[k]) begin
                  m_busy      = 1'b1;
                  m_owner     = k;
                  m_len       = int'(req_cnt_val_i[k*W +: W]);
                  m_arb       = cyc;
                  have_ev     = 1'b1;
                  ev.cyc      = cyc;
                  ev.owner    = k;
                  ev.len      = m_len;
                  ev.is_start = (m_len != 0);
                  m_rel       = (m_len != 0) ? -1 : cyc;
               end
            end
         end else if (m_rel >= 0) begin
            if (cyc == m_rel + 1) begin
               m_busy = 1'b0;
               m_ptr  = (m_owner + 1) % N;
            end
         end else if (cyc >= m_arb + 2) begin
            if (cnt_done_i) begin
               m_rel = cyc;
            end else if (cyc == m_arb + WD + 1) begin
               m_rel   = cyc;
               set_err = 1'b1;
            end
            if (m_rel >= 0) begin
               have_ev     = 1'b1;
               ev.cyc      = cyc;
               ev.is_start = 1'b0;
               ev.owner    = m_owner;
               ev.len      = m_len;
            end
         end
         if (set_err)        m_err = 1'b1;
         else if (err_clr_i) m_err = 1'b0;
         if (have_ev) begin
            ev.err = m_err;
            exp_q.push_back(ev);
         end
      end
   end

   // Monitor: status every cycle, pulses against the scoreboard.
   always @(negedge clk) begin
      ev_t ev;
      if (mon_en) begin
         chk("busy_o", 32'(busy_o), 32'(m_busy));
         chk("grant_o", 32'(grant_o), m_busy ? (32'd1 << m_owner) : 32'd0);
         chk("err_o", 32'(err_o), 32'(m_err));
         chk("cnt_val_o", 32'(cnt_val_o), 32'(m_len));
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ev = exp_q.pop_front();
            chk("start_o", 32'(start_o), 32'(ev.is_start));
            chk("done_o", 32'(done_o), ev.is_start ? 32'd0 : (32'd1 << ev.owner));
            if (ev.is_start) chk("start_len", 32'(cnt_val_o), 32'(ev.len));
            else             chk("done_err", 32'(err_o), 32'(ev.err));
         end else begin
            chk("stray_pulse", 32'({start_o, done_o}), 32'd0);
         end
      end
   end

   task automatic drive_cycle(input bit active);
      rst        = active && ($urandom_range(0, 999) < 3);
      err_clr_i  = active && ($urandom_range(0, 99) < 5);
      cnt_done_i = 1'b0;
      // Counter stand-in: answers after 1..20 WAIT cycles, or never.
      if (start_o) begin
         resp_cd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 20));
      end else if (resp_cd > 0) begin
         resp_cd--;
         if (resp_cd == 0) begin
            cnt_done_i = 1'b1;
            resp_cd    = -1;
         end
      end
      if (active && $urandom_range(0, 99) < 2) cnt_done_i = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (req_i[k] && done_o[k]) begin
            req_i[k] = 1'b0;
         end else if (!req_i[k] && active && $urandom_range(0, 99) < 10) begin
            req_i[k] = 1'b1;
            req_cnt_val_i[k*W +: W] = rand_len();
         end else if ($urandom_range(0, 99) < 5) begin
            req_cnt_val_i[k*W +: W] = W'($urandom_range(0, 127));
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      req_i         = '0;
      req_cnt_val_i = '0;
      err_clr_i     = 1'b0;
      cnt_done_i    = 1'b0;
      @(posedge clk);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         drive_cycle(1'b1);
      end
      for (int c = 0; c < 400 && (req_i != '0 || busy_o); c++) begin
         @(negedge clk);
         drive_cycle(1'b0);
      end
      chk("drain_idle", 32'({|req_i, busy_o}), 32'd0);
      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
